// File: rtl/sfp_link_sequencer_pkg.sv
// sfp_seq_pkg: shared types and helpers for the SFP link sequencer.
//   lane_state_t : per-lane FSM state (2 bits, encoding visible on lane_state)
//   RETRY_W      : width of the per-lane saturating retry counter
//   max2/cnt_w   : helpers for sizing counters from cycle-count parameters
package sfp_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_WAIT_LINK = 2'd2,
    ST_UP        = 2'd3
  } lane_state_t;

  localparam int unsigned RETRY_W = 8;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width able to hold 0..n-1, never below 1 bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfp_link_sequencer_if.sv
// sfp_link_sequencer_if: lane-side bundle of the SFP link sequencer.
//   force_restart   : per-lane single-cycle restart request (sysclk domain)
//   pcs_resetdone   : per-lane core reset-done (asynchronous)
//   pcs_link_status : per-lane core link status (asynchronous)
//   pcs_reset       : per-lane active-high core reset
//   link_up         : per-lane UP indication
//   lane_state      : lane i state in bits [2i+1:2i]
//   retry_count     : lane i retry count in bits [8i+7:8i]
//   sleds           : board status LEDs
// master = sequencer side, slave = lane/system side.
interface sfp_link_sequencer_if
  import sfp_seq_pkg::*;
#(
  parameter int unsigned SFP_COUNT = 2
) ();

  logic [SFP_COUNT-1:0]         force_restart;
  logic [SFP_COUNT-1:0]         pcs_resetdone;
  logic [SFP_COUNT-1:0]         pcs_link_status;
  logic [SFP_COUNT-1:0]         pcs_reset;
  logic [SFP_COUNT-1:0]         link_up;
  logic [2*SFP_COUNT-1:0]       lane_state;
  logic [RETRY_W*SFP_COUNT-1:0] retry_count;
  logic [3:0]                   sleds;

  modport master (
    input  force_restart, pcs_resetdone, pcs_link_status,
    output pcs_reset, link_up, lane_state, retry_count, sleds
  );

  modport slave (
    output force_restart, pcs_resetdone, pcs_link_status,
    input  pcs_reset, link_up, lane_state, retry_count, sleds
  );

endinterface

// File: rtl/sfp_lane_fsm.sv
// sfp_lane_fsm: bring-up controller for one PCS/PMA lane.
//   clk, rst_n      : clock, asynchronous active-low reset
//   force_restart   : restart request, jumps to RESET without counting a retry
//   pcs_resetdone   : core reset-done (2-flop synchronized here)
//   pcs_link_status : core link status (2-flop synchronized here)
//   pcs_reset       : registered core reset, high in RESET
//   link_up         : registered, high in UP
//   lane_state      : current FSM state
//   retry_count     : saturating count of timeout / link-loss restarts
module sfp_lane_fsm
  import sfp_seq_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYC   = 16,
  parameter int unsigned DONE_TIMEOUT_CYC = 1_000_000,
  parameter int unsigned LINK_STABLE_CYC  = 100_000,
  parameter int unsigned LINK_TIMEOUT_CYC = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               force_restart,
  input  logic               pcs_resetdone,
  input  logic               pcs_link_status,
  output logic               pcs_reset,
  output logic               link_up,
  output lane_state_t        lane_state,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int unsigned MAX_CYC = max2(max2(RESET_HOLD_CYC, DONE_TIMEOUT_CYC),
                                         max2(LINK_STABLE_CYC, LINK_TIMEOUT_CYC));
  localparam int unsigned CW = cnt_w(MAX_CYC);
  localparam int unsigned SW = cnt_w(LINK_STABLE_CYC);

  localparam logic [CW-1:0] HOLD_M1  = CW'(RESET_HOLD_CYC - 1);
  localparam logic [CW-1:0] DONE_M1  = CW'(DONE_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] LTO_M1   = CW'(LINK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] DOWN_M1  = CW'(LINK_STABLE_CYC - 1);
  localparam logic [SW-1:0] STB_M1   = SW'(LINK_STABLE_CYC - 1);

  logic [1:0]    done_sync;
  logic [1:0]    link_sync;
  logic          done_s;
  logic          link_s;
  logic [CW-1:0] cnt;   // per-state counter: hold, timeouts, or link-low run in UP
  logic [SW-1:0] stab;  // consecutive link-high run in WAIT_LINK

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_sync <= '0;
      link_sync <= '0;
    end else begin
      done_sync <= {done_sync[0], pcs_resetdone};
      link_sync <= {link_sync[0], pcs_link_status};
    end
  end

  assign done_s = done_sync[1];
  assign link_s = link_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_state  <= ST_RESET;
      cnt         <= '0;
      stab        <= '0;
      retry_count <= '0;
      pcs_reset   <= 1'b1;
      link_up     <= 1'b0;
    end else if (force_restart) begin
      lane_state <= ST_RESET;
      cnt        <= '0;
      stab       <= '0;
      pcs_reset  <= 1'b1;
      link_up    <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      unique case (lane_state)
        ST_RESET: begin
          if (cnt == HOLD_M1) begin
            lane_state <= ST_WAIT_DONE;
            cnt        <= '0;
            pcs_reset  <= 1'b0;
          end
        end
        ST_WAIT_DONE: begin
          if (done_s) begin
            lane_state <= ST_WAIT_LINK;
            cnt        <= '0;
            stab       <= '0;
          end else if (cnt == DONE_M1) begin
            lane_state <= ST_RESET;
            cnt        <= '0;
            pcs_reset  <= 1'b1;
            if (retry_count != '1) retry_count <= retry_count + 1'b1;
          end
        end
        ST_WAIT_LINK: begin
          stab <= link_s ? stab + 1'b1 : '0;
          // stability is tested first so it wins over a coincident timeout
          if (link_s && stab == STB_M1) begin
            lane_state <= ST_UP;
            cnt        <= '0;
            link_up    <= 1'b1;
          end else if (cnt == LTO_M1) begin
            lane_state <= ST_RESET;
            cnt        <= '0;
            stab       <= '0;
            pcs_reset  <= 1'b1;
            if (retry_count != '1) retry_count <= retry_count + 1'b1;
          end
        end
        ST_UP: begin
          cnt <= link_s ? '0 : cnt + 1'b1;
          if (!done_s || (!link_s && cnt == DOWN_M1)) begin
            lane_state <= ST_RESET;
            cnt        <= '0;
            stab       <= '0;
            pcs_reset  <= 1'b1;
            link_up    <= 1'b0;
            if (retry_count != '1) retry_count <= retry_count + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sfp_link_sequencer.sv
// sfp_link_sequencer: per-lane SFP PCS/PMA bring-up with status LEDs.
//   sysclk_100m : sole clock
//   sys_reset_n : asynchronous active-low reset
//   bus         : lane bundle (master side), see sfp_link_sequencer_if
// sleds[0] heartbeat, sleds[1] lane 0 up, sleds[2] lane 1 up, sleds[3] all up.
module sfp_link_sequencer
  import sfp_seq_pkg::*;
#(
  parameter int unsigned SFP_COUNT        = 2,
  parameter int unsigned RESET_HOLD_CYC   = 16,
  parameter int unsigned DONE_TIMEOUT_CYC = 1_000_000,
  parameter int unsigned LINK_STABLE_CYC  = 100_000,
  parameter int unsigned LINK_TIMEOUT_CYC = 50_000_000,
  parameter int unsigned HEARTBEAT_CYC    = 50_000_000
) (
  input  logic                 sysclk_100m,
  input  logic                 sys_reset_n,
  sfp_link_sequencer_if.master bus
);

  localparam int unsigned    HW    = cnt_w(HEARTBEAT_CYC);
  localparam logic [HW-1:0]  HB_M1 = HW'(HEARTBEAT_CYC - 1);

  logic [HW-1:0] hb_cnt;
  logic          hb;

  for (genvar i = 0; i < SFP_COUNT; i++) begin : g_lane
    lane_state_t st;

    sfp_lane_fsm #(
      .RESET_HOLD_CYC   (RESET_HOLD_CYC),
      .DONE_TIMEOUT_CYC (DONE_TIMEOUT_CYC),
      .LINK_STABLE_CYC  (LINK_STABLE_CYC),
      .LINK_TIMEOUT_CYC (LINK_TIMEOUT_CYC)
    ) u_lane (
      .clk             (sysclk_100m),
      .rst_n           (sys_reset_n),
      .force_restart   (bus.force_restart[i]),
      .pcs_resetdone   (bus.pcs_resetdone[i]),
      .pcs_link_status (bus.pcs_link_status[i]),
      .pcs_reset       (bus.pcs_reset[i]),
      .link_up         (bus.link_up[i]),
      .lane_state      (st),
      .retry_count     (bus.retry_count[RETRY_W*i +: RETRY_W])
    );

    assign bus.lane_state[2*i +: 2] = st;
  end

  always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_M1) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
    end
  end

  assign bus.sleds[0] = hb;
  assign bus.sleds[1] = bus.link_up[0];
  assign bus.sleds[3] = &bus.link_up;

  if (SFP_COUNT > 1) begin : g_led2
    assign bus.sleds[2] = bus.link_up[1];
  end else begin : g_led2_off
    assign bus.sleds[2] = 1'b0;
  end

endmodule

// File: doc/sfp_link_sequencer.md
# sfp_link_sequencer

Per-lane bring-up controller for the SFP 1000BASE-X PCS/PMA lanes. It holds each lane's PCS/PMA core in reset, waits for reset completion and a stable link, and retries on timeout or link loss. It reports per-lane link state and drives the four board status LEDs. It sits between the system control block (sysclk_100m, reset) and the PCS/PMA lane instances inside the SFP test top.

## Interface
Parameters:
- SFP_COUNT, 2, number of lanes (1..8)
- RESET_HOLD_CYC, 16, cycles pcs_reset is held high per attempt (>=2)
- DONE_TIMEOUT_CYC, 1_000_000, max cycles waiting for resetdone
- LINK_STABLE_CYC, 100_000, consecutive cycles link must be high to declare up, or low to declare down
- LINK_TIMEOUT_CYC, 50_000_000, max cycles in WAIT_LINK
- HEARTBEAT_CYC, 50_000_000, half-period of the heartbeat LED

Ports:
- sysclk_100m  in  1  sole clock
- sys_reset_n  in  1  reset, asynchronous assert, active-low
- force_restart  in  SFP_COUNT  per-lane single-cycle restart request
- pcs_resetdone  in  SFP_COUNT  core reset-done, asynchronous to sysclk_100m
- pcs_link_status  in  SFP_COUNT  core status_vector[0], asynchronous
- pcs_reset  out  SFP_COUNT  active-high core reset
- link_up  out  SFP_COUNT  lane in UP state
- lane_state  out  2*SFP_COUNT  lane i state in bits [2i+1:2i]
- retry_count  out  8*SFP_COUNT  per-lane saturating retry count
- sleds  out  4  status LEDs

## Operation
- Each lane runs an independent FSM with states RESET=0, WAIT_DONE=1, WAIT_LINK=2, UP=3. Every state has its own cycle counter, which clears on entry.
- RESET: pcs_reset=1. After RESET_HOLD_CYC cycles, go to WAIT_DONE.
- WAIT_DONE: pcs_reset=0.
  - Synchronized resetdone=1 → WAIT_LINK.
  - Counter reaches DONE_TIMEOUT_CYC-1 → RESET, retry++.
- WAIT_LINK:
  - Stability counter counts consecutive cycles of synchronized link=1 and clears when link=0.
  - Stability counter reaches LINK_STABLE_CYC-1 → UP.
  - Timeout counter reaches LINK_TIMEOUT_CYC-1 → RESET, retry++.
  - Stable and timeout in the same cycle → UP wins.
- UP: link_up=1.
  - Counts consecutive link=0 cycles; reaching LINK_STABLE_CYC-1 → RESET, retry++.
  - Link low for fewer cycles is ignored.
  - resetdone dropping → RESET, retry++.
- force_restart[i] in any state → RESET next cycle; retry is not incremented. It overrides all other transitions in that cycle.
- retry_count saturates at 255 and clears only on sys_reset_n.
- LEDs:
  - sleds[0] = heartbeat, toggling every HEARTBEAT_CYC cycles.
  - sleds[1] = link_up[0].
  - sleds[2] = link_up[1] if SFP_COUNT>1, else 0.
  - sleds[3] = AND of all link_up.

## Timing
- Reset values: every lane in RESET, pcs_reset all 1, link_up 0, lane_state 0, retry_count 0, sleds 0, all counters 0.
- The first RESET after sys_reset_n deasserts lasts exactly RESET_HOLD_CYC cycles.
- pcs_resetdone and pcs_link_status pass through 2-flop synchronizers, so input-to-FSM latency is 2 cycles.
- All outputs are registered and change on the cycle after the state transition.
- Entering UP requires link high at the FSM for LINK_STABLE_CYC consecutive cycles: link_up rises LINK_STABLE_CYC+2 cycles after the raw input rises (given the lane is already in WAIT_LINK).
- sys_reset_n asserted mid-operation forces all outputs to reset values immediately (asynchronous). Lanes restart from RESET.

## Structure
- Package sfp_seq_pkg holds:
  - the lane_state_t enum (ST_RESET, ST_WAIT_DONE, ST_WAIT_LINK, ST_UP; 2 bits);
  - the retry counter width constant (8).
- Sub-module sfp_lane_fsm is one lane: synchronizers, FSM, counters, retry counter. The top generates SFP_COUNT instances and adds the heartbeat and LED logic.
- Counter widths are $clog2 of the largest relevant parameter.

## Test plan
Bench parameters: RESET_HOLD_CYC=4, DONE_TIMEOUT_CYC=20, LINK_STABLE_CYC=8, LINK_TIMEOUT_CYC=50, HEARTBEAT_CYC=10.
- Release reset, resetdone=1 at cycle 10, link=1 at cycle 15. Required: pcs_reset high cycles 0-3; link_up[0] rises at cycle 25; sleds[1]=1.
- resetdone held 0. Required: lane cycles RESET (4) → WAIT_DONE (20) repeatedly; retry_count increments every 24 cycles and saturates at 255.
- In UP, link drops for 5 cycles and returns. Required: no state change, retry unchanged. Then drop for 8 cycles. Required: RESET, retry_count=1.
- force_restart pulse while in UP, with a simultaneous link-loss expiry. Required: RESET next cycle, retry unchanged.
- Assert sys_reset_n mid-WAIT_LINK with retry_count=3. Required: all outputs to reset values immediately; retry_count=0.
- Both lanes up. Required: sleds=4'b111x with heartbeat on sleds[0] toggling every 10 cycles. Lane 1 link lost. Required: sleds[2] and sleds[3] fall, sleds[1] stays 1.
